operand_fetch_stage: RTL and testbench

//  ID/EX boundary stage directly downstream of Reg_File: drives a1/a2, consumes rd1/rd2, resolves operands.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/operand_fetch_stage_if.sv | 18 +
 rtl/fwd_mux.sv | 41 ++++
 rtl/operand_fetch_stage.sv | 130 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer pipeline: datapath widths,
// the architectural zero register and the opaque ALU operation codes.
package riscv_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int PC_WIDTH      = 32;

  localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Register-file read port: the stage drives both read addresses and
// receives the matching read data in the same cycle.
interface operand_fetch_stage_if
  import riscv_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDRESS_WIDTH
);

  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  modport master (output a1, output a2, input rd1, input rd2);
  modport slave  (input a1, input a2, output rd1, output rd2);

endinterface

// File: rtl/fwd_mux.sv
// Operand resolver for one source register: picks the youngest in-flight
// producer of the register, falling back to the register-file read data.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDRESS_WIDTH
) (
  input  logic [AW-1:0] src,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] alu_result,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  input  logic [DW-1:0] rf_data,
  output logic [DW-1:0] operand
);

  localparam logic [AW-1:0] SRC_ZERO = AW'(REG_ZERO);

  // A load in EX has no data yet; the hazard logic stalls that case instead.
  always_comb begin
    operand = rf_data;
    if (src == SRC_ZERO) begin
      operand = '0;
    end else if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == src)) begin
      operand = alu_result;
    end else if (mem_reg_write && (mem_rd == src)) begin
      operand = mem_result;
    end else if (wb_reg_write && (wb_rd == src)) begin
      operand = wb_result;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX boundary: reads the register file, resolves bypassed operands,
// stalls decode on load-use hazards and registers the result into EX.
module operand_fetch_stage #(
  parameter int DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = riscv_pkg::ADDRESS_WIDTH,
  parameter int PC_WIDTH      = riscv_pkg::PC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2,
  input  logic [ADDRESS_WIDTH-1:0] id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [3:0]               id_alu_ctrl,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [PC_WIDTH-1:0]      id_pc,
  operand_fetch_stage_if.master    rf,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  input  logic                     flush,
  input  logic                     ex_hold,
  output logic                     id_stall,
  output logic                     ex_valid,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [3:0]               ex_alu_ctrl,
  output logic [DATA_WIDTH-1:0]    ex_op1,
  output logic [DATA_WIDTH-1:0]    ex_op2,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [PC_WIDTH-1:0]      ex_pc,
  output logic [15:0]              stall_cnt
);

  localparam logic [ADDRESS_WIDTH-1:0] RD_ZERO = ADDRESS_WIDTH'(riscv_pkg::REG_ZERO);

  logic [DATA_WIDTH-1:0] op1_resolved;
  logic [DATA_WIDTH-1:0] op2_resolved;
  logic                  luh;

  assign rf.a1 = id_rs1;
  assign rf.a2 = id_rs2;

  fwd_mux #(.DW(DATA_WIDTH), .AW(ADDRESS_WIDTH)) u_fwd_op1 (
    .src           (id_rs1),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .alu_result    (alu_result),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .rf_data       (rf.rd1),
    .operand       (op1_resolved)
  );

  fwd_mux #(.DW(DATA_WIDTH), .AW(ADDRESS_WIDTH)) u_fwd_op2 (
    .src           (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .alu_result    (alu_result),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .rf_data       (rf.rd2),
    .operand       (op2_resolved)
  );

  // Handshake: decode offers an instruction with id_valid; it is accepted at
  // a clock edge only when id_stall is low, otherwise decode must hold it.
  assign luh = id_valid && ex_valid && ex_mem_read && (ex_rd != RD_ZERO) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign id_stall = ex_hold || (luh && !flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_alu_ctrl  <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      stall_cnt    <= '0;
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (luh) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end else begin
      ex_valid     <= id_valid;
      ex_rd        <= id_rd;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_alu_ctrl  <= id_alu_ctrl;
      ex_op1       <= op1_resolved;
      ex_op2       <= op2_resolved;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding priority, load-use
// stall, x0 handling, flush/hold and asynchronous reset.
module tb_operand_fetch_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_imm, id_pc;
  logic [31:0] alu_result, mem_result, wb_result;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic        flush, ex_hold;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  operand_fetch_stage_if rf_if ();

  operand_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_alu_ctrl   (id_alu_ctrl),
    .id_imm        (id_imm),
    .id_pc         (id_pc),
    .rf            (rf_if.master),
    .alu_result    (alu_result),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .flush         (flush),
    .ex_hold       (ex_hold),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_alu_ctrl   (ex_alu_ctrl),
    .ex_op1        (ex_op1),
    .ex_op2        (ex_op2),
    .ex_imm        (ex_imm),
    .ex_pc         (ex_pc),
    .stall_cnt     (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_alu_ctrl = ALU_ADD;
    id_imm = 0; id_pc = 0;
    rf_if.rd1 = 0; rf_if.rd2 = 0;
    alu_result = 0; mem_result = 0; wb_result = 0;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
    flush = 0; ex_hold = 0;
  endtask

  // Driver: present one instruction in decode
  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [31:0] pc);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_pc = pc;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    if (ex_valid !== 1'b0) begin $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); errors++; end
    checks++;
    if (ex_op1 !== 32'h0) begin $display("FAIL reset_ex_op1: got %h want 0", ex_op1); errors++; end
    checks++;
    if (stall_cnt !== 16'h0) begin $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); errors++; end
    checks++;
    if (id_stall !== 1'b0) begin $display("FAIL reset_id_stall: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_ex_fwd();
    drive_id(5'd1, 5'd2, 5'd5, 1, 0, 32'h100);
    id_alu_ctrl = ALU_SUB; id_imm = 32'h4;
    rf_if.rd1 = 32'h1; rf_if.rd2 = 32'h2;
    step();
    if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin
      $display("FAIL load_ex: got valid=%0b rd=%0d want 1/5", ex_valid, ex_rd); errors++;
    end
    checks++;
    if (ex_op1 !== 32'h1 || ex_op2 !== 32'h2 || ex_imm !== 32'h4 || ex_pc !== 32'h100 || ex_alu_ctrl !== 4'd1) begin
      $display("FAIL load_fields: got op1=%h op2=%h imm=%h pc=%h alu=%h want 1/2/4/100/1",
               ex_op1, ex_op2, ex_imm, ex_pc, ex_alu_ctrl); errors++;
    end
    checks++;
    alu_result = 32'h11;
    drive_id(5'd5, 5'd6, 5'd8, 1, 0, 32'h104);
    rf_if.rd1 = 32'hAA; rf_if.rd2 = 32'h66;
    #1;
    if (rf_if.a1 !== 5'd5 || rf_if.a2 !== 5'd6) begin
      $display("FAIL rf_addr: got a1=%0d a2=%0d want 5/6", rf_if.a1, rf_if.a2); errors++;
    end
    checks++;
    if (id_stall !== 1'b0) begin $display("FAIL ex_fwd_no_stall: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    if (ex_op1 !== 32'h11 || ex_op2 !== 32'h66) begin
      $display("FAIL ex_fwd: got op1=%h op2=%h want 11/66", ex_op1, ex_op2); errors++;
    end
    checks++;
  endtask

  task automatic test_priority();
    drive_id(5'd0, 5'd7, 5'd9, 0, 0, 32'h108);
    rf_if.rd1 = 32'h99; rf_if.rd2 = 32'h44;
    mem_rd = 5'd7; mem_reg_write = 1; mem_result = 32'h22;
    wb_rd = 5'd7; wb_reg_write = 1; wb_result = 32'h33;
    step();
    if (ex_op2 !== 32'h22 || ex_op1 !== 32'h0) begin
      $display("FAIL prio_mem_over_wb: got op1=%h op2=%h want 0/22", ex_op1, ex_op2); errors++;
    end
    checks++;
    mem_reg_write = 0;
    step();
    if (ex_op2 !== 32'h33) begin $display("FAIL prio_wb_only: got %h want 33", ex_op2); errors++; end
    checks++;
    wb_reg_write = 0;
    step();
    if (ex_op2 !== 32'h44) begin $display("FAIL prio_regfile: got %h want 44", ex_op2); errors++; end
    checks++;
    drive_id(5'd0, 5'd0, 5'd7, 1, 0, 32'h10C);
    step();
    drive_id(5'd0, 5'd7, 5'd9, 0, 0, 32'h110);
    alu_result = 32'h55; mem_reg_write = 1; wb_reg_write = 1;
    step();
    if (ex_op2 !== 32'h55) begin $display("FAIL prio_ex_over_mem: got %h want 55", ex_op2); errors++; end
    checks++;
    mem_reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic test_load_use();
    drive_id(5'd0, 5'd0, 5'd3, 1, 1, 32'h114);
    step();
    if (ex_mem_read !== 1'b1) begin $display("FAIL lw_in_ex: got %0b want 1", ex_mem_read); errors++; end
    checks++;
    drive_id(5'd0, 5'd3, 5'd9, 1, 0, 32'h118);
    rf_if.rd2 = 32'hDEAD;
    #1;
    if (id_stall !== 1'b1) begin $display("FAIL luh_stall: got %0b want 1", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      $display("FAIL luh_bubble: got v=%0b rw=%0b mr=%0b want 0/0/0", ex_valid, ex_reg_write, ex_mem_read); errors++;
    end
    checks++;
    if (stall_cnt !== 16'd1) begin $display("FAIL luh_cnt: got %0d want 1", stall_cnt); errors++; end
    checks++;
    if (id_stall !== 1'b0) begin $display("FAIL luh_one_cycle: got %0b want 0", id_stall); errors++; end
    checks++;
    mem_rd = 5'd3; mem_reg_write = 1; mem_result = 32'h77;
    step();
    if (ex_valid !== 1'b1 || ex_op2 !== 32'h77 || ex_rd !== 5'd9) begin
      $display("FAIL luh_resume: got v=%0b op2=%h rd=%0d want 1/77/9", ex_valid, ex_op2, ex_rd); errors++;
    end
    checks++;
    mem_reg_write = 0;
  endtask

  task automatic test_x0();
    drive_id(5'd0, 5'd0, 5'd0, 1, 0, 32'h11C);
    step();
    alu_result = 32'hFF; mem_rd = 5'd0; mem_reg_write = 1; mem_result = 32'hEE;
    drive_id(5'd0, 5'd0, 5'd9, 0, 0, 32'h120);
    rf_if.rd1 = 32'h12; rf_if.rd2 = 32'h34;
    step();
    if (ex_op1 !== 32'h0 || ex_op2 !== 32'h0) begin
      $display("FAIL x0_zero: got op1=%h op2=%h want 0/0", ex_op1, ex_op2); errors++;
    end
    checks++;
    mem_reg_write = 0;
    drive_id(5'd0, 5'd0, 5'd0, 1, 1, 32'h124);
    step();
    drive_id(5'd0, 5'd0, 5'd9, 1, 0, 32'h128);
    #1;
    if (id_stall !== 1'b0) begin $display("FAIL x0_no_stall: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b1 || stall_cnt !== 16'd1) begin
      $display("FAIL x0_pass: got v=%0b cnt=%0d want 1/1", ex_valid, stall_cnt); errors++;
    end
    checks++;
  endtask

  task automatic test_flush_hold();
    drive_id(5'd1, 5'd2, 5'd10, 1, 0, 32'h12C);
    flush = 1;
    #1;
    if (id_stall !== 1'b0) begin $display("FAIL flush_no_stall: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      $display("FAIL flush_bubble: got v=%0b rw=%0b want 0/0", ex_valid, ex_reg_write); errors++;
    end
    checks++;
    flush = 0;
    drive_id(5'd1, 5'd2, 5'd11, 1, 0, 32'h200);
    id_imm = 32'h80;
    step();
    drive_id(5'd1, 5'd2, 5'd12, 1, 0, 32'h300);
    id_imm = 32'h90;
    ex_hold = 1; flush = 1;
    #1;
    if (id_stall !== 1'b1) begin $display("FAIL hold_stall: got %0b want 1", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || ex_pc !== 32'h200 || ex_imm !== 32'h80) begin
      $display("FAIL hold_keep: got v=%0b rd=%0d pc=%h imm=%h want 1/11/200/80", ex_valid, ex_rd, ex_pc, ex_imm); errors++;
    end
    checks++;
    ex_hold = 0; flush = 0;
    drive_id(5'd0, 5'd0, 5'd4, 1, 1, 32'h304);
    step();
    drive_id(5'd4, 5'd0, 5'd9, 1, 0, 32'h308);
    flush = 1;
    #1;
    if (id_stall !== 1'b0) begin $display("FAIL flush_masks_luh: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      $display("FAIL flush_luh_cnt: got v=%0b cnt=%0d want 0/1", ex_valid, stall_cnt); errors++;
    end
    checks++;
    flush = 0;
  endtask

  task automatic test_mid_reset();
    drive_id(5'd1, 5'd0, 5'd3, 1, 1, 32'h400);
    rf_if.rd1 = 32'h5;
    step();
    drive_id(5'd0, 5'd3, 5'd9, 1, 0, 32'h404);
    rf_if.rd2 = 32'hBEEF;
    #1;
    if (id_stall !== 1'b1 || ex_op1 !== 32'h5 || stall_cnt !== 16'd1) begin
      $display("FAIL pre_reset: got stall=%0b op1=%h cnt=%0d want 1/5/1", id_stall, ex_op1, stall_cnt); errors++;
    end
    checks++;
    #1 rst_n = 0;
    #1;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_op1 !== 32'h0 || stall_cnt !== 16'd0) begin
      $display("FAIL async_reset: got v=%0b mr=%0b op1=%h cnt=%0d want 0/0/0/0", ex_valid, ex_mem_read, ex_op1, stall_cnt); errors++;
    end
    checks++;
    if (id_stall !== 1'b0) begin $display("FAIL reset_clears_luh: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    rst_n = 1;
    #1;
    if (id_stall !== 1'b0) begin $display("FAIL post_reset_stall: got %0b want 0", id_stall); errors++; end
    checks++;
    step();
    if (ex_valid !== 1'b1 || ex_op2 !== 32'hBEEF || stall_cnt !== 16'd0) begin
      $display("FAIL post_reset_issue: got v=%0b op2=%h cnt=%0d want 1/beef/0", ex_valid, ex_op2, stall_cnt); errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use();
    test_x0();
    test_flush_hold();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
